// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: prescaled sec/min/hour/day/month/year counter with leap-year Feb and a set handshake.
// Optional alarm registers and output are enabled by defining ALARM_EN.
module rtc_calendar_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int YEAR_INIT  = 24,
    parameter int MONTH_INIT = 1,
    parameter int DAY_INIT   = 1,
    parameter int PRE_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12h,
    input  logic       set_req,
    input  logic [2:0] set_sel,
    input  logic [6:0] set_val,
`ifdef ALARM_EN
    input  logic       alarm_arm,
    input  logic       alarm_clr,
    output logic       alarm,
`endif
    output logic       set_ack,
    output logic       set_err,
    output logic       sec_pulse,
    output logic [5:0] second,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic       pm,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT} st_e;

    st_e              state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d, min_q, min_d;
    logic [4:0]       hour_q, hour_d, day_q, day_d, dim_cur;
    logic [3:0]       month_q, month_d;
    logic [6:0]       year_q, year_d;
    logic             err_q, err_d, pulse_q, valid, wr, wrap, adv;

    function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [6:0] y);
        return (m == 4'd2) ? ((y[1:0] == 2'b00) ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    always_comb begin
        dim_cur = dim_f(month_q, year_q);
        case (set_sel)
            3'd0, 3'd1: valid = set_val <= 7'd59;
            3'd2:       valid = set_val <= 7'd23;
            3'd3:       valid = set_val >= 7'd1 && set_val <= {2'b00, dim_cur};
            3'd4:       valid = set_val >= 7'd1 && set_val <= 7'd12;
            3'd5:       valid = set_val <= 7'd99;
`ifdef ALARM_EN
            3'd6:       valid = set_val <= 7'd23;
            default:    valid = set_val <= 7'd59;
`else
            default:    valid = 1'b0;
`endif
        endcase
    end

    assign wr   = state_q == IDLE && set_req && valid;
    assign wrap = pre_q == PRE_W'(CLK_HZ - 1);
    // An accepted write restarts the second, so a coincident wrap must not tick.
    assign adv  = wrap && !wr;

    always_comb begin
        pre_d   = (wrap || wr) ? '0 : pre_q + PRE_W'(1);
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        state_d = state_q;
        err_d   = err_q;
        if (adv) begin
            sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (min_q == 6'd59) begin
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    if (hour_q == 5'd23) begin
                        day_d = (day_q == dim_cur) ? 5'd1 : day_q + 5'd1;
                        if (day_q == dim_cur) begin
                            month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                            if (month_q == 4'd12) year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                        end
                    end
                end
            end
        end
        if (wr) begin
            case (set_sel)
                3'd0: sec_d  = set_val[5:0];
                3'd1: min_d  = set_val[5:0];
                3'd2: hour_d = set_val[4:0];
                3'd3: day_d  = set_val[4:0];
                3'd4: begin
                    month_d = set_val[3:0];
                    day_d   = (day_q > dim_f(set_val[3:0], year_q)) ? dim_f(set_val[3:0], year_q) : day_q;
                end
                3'd5: begin
                    year_d = set_val;
                    day_d  = (day_q > dim_f(month_q, set_val)) ? dim_f(month_q, set_val) : day_q;
                end
                default: ;
            endcase
        end
        case (state_q)
            IDLE: if (set_req) begin
                state_d = ACK;
                err_d   = !valid;
            end
            ACK:     state_d = WAIT;
            default: if (!set_req) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= 5'(DAY_INIT);
            month_q <= 4'(MONTH_INIT);
            year_q  <= 7'(YEAR_INIT);
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            err_q   <= err_d;
            pulse_q <= adv;
        end
    end

`ifdef ALARM_EN
    logic [4:0] ahr_q, ahr_d;
    logic [5:0] amin_q, amin_d, acnt_q, acnt_d;
    logic       alarm_q, alarm_d, hit, clr;

    always_comb begin
        ahr_d   = (wr && set_sel == 3'd6) ? set_val[4:0] : ahr_q;
        amin_d  = (wr && set_sel == 3'd7) ? set_val[5:0] : amin_q;
        hit     = adv && alarm_arm && hour_d == ahr_q && min_d == amin_q && sec_d == 6'd0;
        // Self-clears on the 60th second pulse after it fired.
        clr     = alarm_clr || !alarm_arm || (alarm_q && adv && acnt_q == 6'd59);
        alarm_d = clr ? 1'b0 : (hit ? 1'b1 : alarm_q);
        acnt_d  = hit ? 6'd0 : ((alarm_q && adv) ? acnt_q + 6'd1 : acnt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ahr_q   <= '0;
            amin_q  <= '0;
            acnt_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            ahr_q   <= ahr_d;
            amin_q  <= amin_d;
            acnt_q  <= acnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign set_ack   = state_q == ACK;
    assign set_err   = err_q;
    assign sec_pulse = pulse_q;
    assign second    = sec_q;
    assign minute    = min_q;
    assign hour      = !mode_12h ? hour_q : (hour_q == 5'd0) ? 5'd12 : (hour_q > 5'd12) ? hour_q - 5'd12 : hour_q;
    assign pm        = hour_q >= 5'd12;
    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb_rtc_calendar_core: directed checks of rtc_calendar_core at CLK_HZ=4, starting Feb 28 of year 24.
// Exercises the alarm path too when ALARM_EN is defined.
module tb_rtc_calendar_core;
    logic       clk = 1'b0, rst, mode_12h, set_req;
    logic [2:0] set_sel;
    logic [6:0] set_val;
    logic       set_ack, set_err, sec_pulse, pm;
    logic [5:0] second, minute;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year;
    int         n_vec = 0, n_err = 0, acks;
    logic       a, e, sp;
`ifdef ALARM_EN
    logic       alarm_arm, alarm_clr, alarm;
`endif

    rtc_calendar_core #(.CLK_HZ(4), .PRE_W(3), .YEAR_INIT(24), .MONTH_INIT(2), .DAY_INIT(28)) dut (
        .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_req(set_req), .set_sel(set_sel), .set_val(set_val),
`ifdef ALARM_EN
        .alarm_arm(alarm_arm), .alarm_clr(alarm_clr), .alarm(alarm),
`endif
        .set_ack(set_ack), .set_err(set_err), .sec_pulse(sec_pulse), .second(second), .minute(minute),
        .hour(hour), .pm(pm), .day(day), .month(month), .year(year)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request, samples at the cycle after the write edge, then lets the FSM return to IDLE.
    task automatic do_set(input logic [2:0] sel, input logic [6:0] val, output logic ack, output logic err,
                          output logic pulse);
        set_sel = sel;
        set_val = val;
        set_req = 1'b1;
        @(negedge clk);
        ack     = set_ack;
        err     = set_err;
        pulse   = sec_pulse;
        set_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [6:0] val, input logic exp_err);
        do_set(sel, val, a, e, sp);
        chk("set_ack", a, 1);
        chk("set_err", e, exp_err);
    endtask

    initial begin
        rst = 1'b0; mode_12h = 1'b0; set_req = 1'b0; set_sel = '0; set_val = '0;
`ifdef ALARM_EN
        alarm_arm = 1'b0; alarm_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_sec", second, 0); chk("rst_min", minute, 0); chk("rst_hour", hour, 0);
        chk("rst_day", day, 28); chk("rst_month", month, 2); chk("rst_year", year, 24);
        chk("rst_ack", set_ack, 0); chk("rst_err", set_err, 0); chk("rst_pulse", sec_pulse, 0);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("cadence_pulse", sec_pulse, (i % 4) == 0);
            chk("cadence_sec", second, i / 4);
        end
        chk("init_min", minute, 0); chk("init_day", day, 28); chk("init_year", year, 24);
        // Leap Feb: 23:59:59 on Feb 28 of year 24 rolls to Feb 29.
        wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
        repeat (2) @(negedge clk);
        chk("leap_pulse", sec_pulse, 1); chk("leap_sec", second, 0); chk("leap_hour", hour, 0);
        chk("leap_day", day, 29); chk("leap_month", month, 2);
        wr(3, 30, 1);
        chk("feb_bad_day", day, 29);
        wr(3, 29, 0);
        // Year 25 clamps Feb 29 to 28, then rolls into March.
        wr(5, 25, 0);
        chk("year_clamp", day, 28);
        wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
        repeat (2) @(negedge clk);
        chk("mar_day", day, 1); chk("mar_month", month, 3); chk("mar_year", year, 25);
        wr(3, 31, 0); wr(4, 4, 0);
        chk("month_clamp", day, 30); chk("month_set", month, 4);
        // Full year/century rollover.
        wr(5, 99, 0); wr(4, 12, 0); wr(3, 31, 0); wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
        repeat (2) @(negedge clk);
        chk("ny_pulse", sec_pulse, 1); chk("ny_sec", second, 0); chk("ny_min", minute, 0);
        chk("ny_hour", hour, 0); chk("ny_day", day, 1); chk("ny_month", month, 1);
        chk("ny_year", year, 0); chk("ny_pm", pm, 0);
        // 12/24-hour presentation.
        mode_12h = 1'b1;
        wr(2, 13, 0);
        chk("h12_13", hour, 1); chk("pm_13", pm, 1);
        mode_12h = 1'b0;
        #1 chk("h24_13", hour, 13);
        mode_12h = 1'b1;
        wr(2, 0, 0);
        chk("h12_0", hour, 12); chk("pm_0", pm, 0);
        wr(2, 12, 0);
        chk("h12_12", hour, 12); chk("pm_12", pm, 1);
        mode_12h = 1'b0;
        // Out-of-range writes.
        wr(0, 60, 1); wr(2, 24, 1);
        chk("hour_kept", hour, 12);
        wr(4, 13, 1); wr(4, 0, 1); wr(3, 0, 1); wr(5, 100, 1);
        chk("month_kept", month, 1);
`ifndef ALARM_EN
        wr(6, 5, 1); wr(7, 0, 1);
`endif
        // A long-held request yields a single acknowledge.
        set_sel = 3'd1; set_val = 7'd5; set_req = 1'b1; acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acks += int'(set_ack);
        end
        set_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_acks", acks, 1); chk("hold_min", minute, 5);
        // Write landing on the prescaler wrap suppresses that second and restarts the count.
        wr(0, 10, 0);
        @(negedge clk);
        do_set(1, 20, a, e, sp);
        chk("coinc_ack", a, 1); chk("coinc_pulse", sp, 0);
        chk("coinc_sec", second, 10); chk("coinc_min", minute, 20);
        @(negedge clk);
        chk("restart_early", sec_pulse, 0);
        @(negedge clk);
        chk("restart_pulse", sec_pulse, 1); chk("restart_sec", second, 11);
`ifdef ALARM_EN
        alarm_arm = 1'b1;
        wr(6, 7, 0); wr(7, 30, 0); wr(2, 7, 0); wr(1, 29, 0); wr(0, 59, 0);
        chk("alarm_idle", alarm, 0);
        repeat (2) @(negedge clk);
        chk("alarm_fire", alarm, 1); chk("alarm_min", minute, 30); chk("alarm_sec", second, 0);
        alarm_clr = 1'b1;
        @(negedge clk);
        chk("alarm_clr", alarm, 0);
        alarm_clr = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
